// File: rtl/pio_button_irq.sv
// Button/switch input PIO: per-bit sync, debounce, edge capture, maskable irq.
// Avalon-MM slave with DATA, IRQ_MASK and EDGE_CAPTURE registers.
module pio_button_irq #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter int unsigned      EDGE_MODE       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int unsigned DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam int unsigned CW = $clog2(DB + 1);
   localparam logic [CW-1:0] CMAX = CW'(DB - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] deb_q, deb_d, deb_dly_q;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] edge_w, clr_w;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q, irq_d;
   logic             wr_w;

   if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
   end

   // deb only follows sync2 after DB consecutive differing cycles
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CMAX) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      edge_w = ~deb_q & deb_dly_q;
      if (EDGE_MODE == 0) begin
         edge_w = deb_q & ~deb_dly_q;
      end else if (EDGE_MODE == 2) begin
         edge_w = deb_q ^ deb_dly_q;
      end
   end

   assign wr_w = chipselect & ~write_n;

   always_comb begin
      mask_d = mask_q;
      clr_w  = '0;
      if (wr_w && address == 2'd2) begin
         mask_d = writedata[WIDTH-1:0];
      end
      if (wr_w && address == 2'd3) begin
         clr_w = writedata[WIDTH-1:0];
      end
      // a same-cycle edge beats the clear
      cap_d = (cap_q & ~clr_w) | edge_w;
      irq_d = |(cap_q & mask_q);
   end

   always_comb begin
      rdata_d = '0;
      unique case (address)
         2'd0:    rdata_d[WIDTH-1:0] = deb_q;
         2'd2:    rdata_d[WIDTH-1:0] = mask_q;
         2'd3:    rdata_d[WIDTH-1:0] = cap_q;
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= RESET_VALUE;
         sync2_q   <= RESET_VALUE;
         deb_q     <= RESET_VALUE;
         deb_dly_q <= RESET_VALUE;
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
         mask_q    <= '0;
         cap_q     <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync1_q   <= in_port;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
         mask_q    <= mask_d;
         cap_q     <= cap_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign readdata = rdata_q;
   assign irq      = irq_q;

endmodule
